// File: rtl/dorm_keypad_lock.sv
// dorm_keypad_lock: multi-digit keypad door controller with a timed open window,
// consecutive-failure lockout and a hold-open override for event mode.
// Optional feature macro: CODE_PROGRAM_EN (code_load reprograms the code in OPEN/HOLD).
module dorm_keypad_lock #(
  parameter int unsigned                     CODE_DIGITS    = 4,
  parameter int unsigned                     DIGIT_W        = 4,
  parameter logic [CODE_DIGITS*DIGIT_W-1:0]  DEFAULT_CODE   = 16'h1234,
  parameter int unsigned                     OPEN_CYCLES    = 500,
  parameter int unsigned                     ENTRY_TIMEOUT  = 200,
  parameter int unsigned                     MAX_FAIL       = 3,
  parameter int unsigned                     LOCKOUT_CYCLES = 1000,
  localparam int unsigned                    CODE_W         = CODE_DIGITS * DIGIT_W,
  localparam int unsigned                    FAIL_W         = $clog2(MAX_FAIL + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_digit_valid,
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic              i_hold_open,
  input  logic              i_code_load,
  input  logic [CODE_W-1:0] i_new_code,
  output logic              o_door_open,
  output logic              o_lockout,
  output logic              o_entry_active,
  output logic [FAIL_W-1:0] o_fail_count
);

  localparam int unsigned T_MAX_OL = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                     : LOCKOUT_CYCLES;
  localparam int unsigned T_MAX    = (T_MAX_OL > ENTRY_TIMEOUT) ? T_MAX_OL : ENTRY_TIMEOUT;
  // Timers hold at most T_MAX-1: they count down to zero / up to the limit minus one.
  localparam int unsigned TIMER_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int unsigned IDX_W    = (CODE_DIGITS > 1) ? $clog2(CODE_DIGITS) : 1;

  typedef enum logic [2:0] {StLocked, StEntry, StOpen, StLockout, StHold} state_e;

  state_e             r_state;
  logic [CODE_W-1:0]  r_code;
  logic [IDX_W-1:0]   r_idx;
  logic               r_match;
  logic [TIMER_W-1:0] r_timer;
  logic [FAIL_W-1:0]  r_fail;
  logic               r_door_open;
  logic               r_lockout;
  logic               r_entry_active;

  logic [DIGIT_W-1:0] w_exp_digit;
  logic               w_match_acc;
  logic               w_last;
  logic [FAIL_W-1:0]  w_fail_inc;

  // Select the code digit expected at the current index (digit 0 is the MS slice).
  always_comb begin
    w_exp_digit = '0;
    for (int unsigned i = 0; i < CODE_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_exp_digit = r_code[(CODE_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // r_idx is always zero outside ENTRY, so LOCKED naturally checks slice 0.
  assign w_match_acc = ((r_state == StEntry) ? r_match : 1'b1) & (i_digit == w_exp_digit);
  assign w_last      = (r_idx == IDX_W'(CODE_DIGITS - 1));
  assign w_fail_inc  = r_fail + 1'b1;

`ifndef CODE_PROGRAM_EN
  logic w_unused;
  assign w_unused = ^{i_code_load, i_new_code};
`endif

  // Main FSM: mode, timers, entry progress, code register and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= StLocked;
      r_code         <= DEFAULT_CODE;
      r_idx          <= '0;
      r_match        <= 1'b0;
      r_timer        <= '0;
      r_fail         <= '0;
      r_door_open    <= 1'b0;
      r_lockout      <= 1'b0;
      r_entry_active <= 1'b0;
    end else begin
`ifdef CODE_PROGRAM_EN
      if (i_code_load && (r_state == StOpen || r_state == StHold)) begin
        r_code <= i_new_code;
      end
`endif
      if (i_hold_open) begin
        // Emergency egress / event mode beats everything, including lockout.
        r_state        <= StHold;
        r_idx          <= '0;
        r_match        <= 1'b0;
        r_timer        <= '0;
        r_fail         <= '0;
        r_door_open    <= 1'b1;
        r_lockout      <= 1'b0;
        r_entry_active <= 1'b0;
      end else begin
        unique case (r_state)
          StLocked, StEntry: begin
            if (i_digit_valid) begin
              r_timer <= '0;
              if (w_last) begin
                r_idx          <= '0;
                r_match        <= 1'b0;
                r_entry_active <= 1'b0;
                if (w_match_acc) begin
                  r_state     <= StOpen;
                  r_timer     <= TIMER_W'(OPEN_CYCLES - 1);
                  r_door_open <= 1'b1;
                  r_fail      <= '0;
                end else if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
                  r_state   <= StLockout;
                  r_timer   <= TIMER_W'(LOCKOUT_CYCLES - 1);
                  r_lockout <= 1'b1;
                  r_fail    <= '0;
                end else begin
                  r_state <= StLocked;
                  r_fail  <= w_fail_inc;
                end
              end else begin
                r_state        <= StEntry;
                r_idx          <= r_idx + 1'b1;
                r_match        <= w_match_acc;
                r_entry_active <= 1'b1;
              end
            end else if (r_state == StEntry) begin
              if (r_timer == TIMER_W'(ENTRY_TIMEOUT - 1)) begin
                r_state        <= StLocked;
                r_idx          <= '0;
                r_match        <= 1'b0;
                r_timer        <= '0;
                r_entry_active <= 1'b0;
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
          end
          StOpen: begin
            if (r_timer == '0) begin
              r_state     <= StLocked;
              r_door_open <= 1'b0;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          StLockout: begin
            if (r_timer == '0) begin
              r_state   <= StLocked;
              r_lockout <= 1'b0;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          StHold: begin
            r_state     <= StLocked;
            r_door_open <= 1'b0;
          end
          default: begin
            r_state        <= StLocked;
            r_idx          <= '0;
            r_timer        <= '0;
            r_door_open    <= 1'b0;
            r_lockout      <= 1'b0;
            r_entry_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_door_open    = r_door_open;
  assign o_lockout      = r_lockout;
  assign o_entry_active = r_entry_active;
  assign o_fail_count   = r_fail;

endmodule

// File: tb/tb_dorm_keypad_lock.sv
// Self-checking bench for dorm_keypad_lock: vector table, directed corner sequences and a
// randomized run against a queue-based reference model. Honours CODE_PROGRAM_EN if defined.
module tb_dorm_keypad_lock;

  localparam int unsigned OPEN_C   = 8;
  localparam int unsigned TMO      = 10;
  localparam int unsigned MAXF     = 3;
  localparam int unsigned LOCK_C   = 16;
  localparam logic [15:0] DEF_CODE = 16'h1234;
  localparam int          NTBL     = 18;

  logic        clk;
  logic        reset;
  logic        dv;
  logic [3:0]  dg;
  logic        ho;
  logic        cl;
  logic [15:0] nc;
  logic        door;
  logic        lock;
  logic        entry;
  logic [1:0]  fcnt;

  int checks   = 0;
  int failures = 0;
  int cnt;
  int opened;

  // Reference model: counts of remaining open/lockout cycles and a queue of typed digits.
  bit          m_hold;
  int          m_open;
  int          m_lock;
  int          m_digits[$];
  int          m_idle;
  int          m_fails;
  logic [15:0] m_code;

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic [4:0] want;  // {door, lockout, entry, fail[1:0]}
  } vec_t;
  vec_t tbl[NTBL];

  dorm_keypad_lock #(
    .CODE_DIGITS   (4),
    .DIGIT_W       (4),
    .DEFAULT_CODE  (DEF_CODE),
    .OPEN_CYCLES   (OPEN_C),
    .ENTRY_TIMEOUT (TMO),
    .MAX_FAIL      (MAXF),
    .LOCKOUT_CYCLES(LOCK_C)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_digit_valid (dv),
    .i_digit       (dg),
    .i_hold_open   (ho),
    .i_code_load   (cl),
    .i_new_code    (nc),
    .o_door_open   (door),
    .o_lockout     (lock),
    .o_entry_active(entry),
    .o_fail_count  (fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] code_digit(input logic [15:0] c, input int i);
    return c[(3-i)*4 +: 4];
  endfunction

  task automatic model_reset();
    m_hold  = 1'b0;
    m_open  = 0;
    m_lock  = 0;
    m_digits.delete();
    m_idle  = 0;
    m_fails = 0;
    m_code  = DEF_CODE;
  endtask

  task automatic model_edge(input logic idv, input logic [3:0] id, input logic iho,
                            input logic icl, input logic [15:0] inc);
    logic [15:0] code_nxt;
    bit ok;
    code_nxt = m_code;
`ifdef CODE_PROGRAM_EN
    if (icl && (m_hold || m_open > 0)) code_nxt = inc;
`else
    if (icl && inc == 16'hxxxx) code_nxt = m_code;
`endif
    if (iho) begin
      m_hold  = 1'b1;
      m_open  = 0;
      m_lock  = 0;
      m_digits.delete();
      m_idle  = 0;
      m_fails = 0;
    end else if (m_hold) begin
      m_hold = 1'b0;
    end else if (m_open > 0) begin
      m_open--;
    end else if (m_lock > 0) begin
      m_lock--;
    end else if (idv) begin
      m_digits.push_back(int'(id));
      m_idle = 0;
      if (m_digits.size() == 4) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (m_digits[i] != int'(code_digit(m_code, i))) ok = 1'b0;
        m_digits.delete();
        if (ok) begin
          m_open  = OPEN_C;
          m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == MAXF) begin
            m_fails = 0;
            m_lock  = LOCK_C;
          end
        end
      end
    end else if (m_digits.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) m_digits.delete();
    end
    m_code = code_nxt;
  endtask

  function automatic logic [4:0] model_out();
    return {(m_hold || m_open > 0), (m_lock > 0), (m_digits.size() > 0), 2'(m_fails)};
  endfunction

  task automatic chk_out(input string name, input logic [4:0] want);
    logic [4:0] got;
    got = {door, lock, entry, fcnt};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: {door,lockout,entry,fail} got %b want %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, sample 1 time unit later.
  task automatic step(input logic idv, input logic [3:0] id, input logic iho,
                      input logic icl, input logic [15:0] inc);
    dv = idv; dg = id; ho = iho; cl = icl; nc = inc;
    @(posedge clk);
    model_edge(idv, id, iho, icl, inc);
    #1;
    dv = 1'b0; dg = '0; ho = 1'b0; cl = 1'b0; nc = '0;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) step(1'b1, code_digit(c, i), 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset_immediate", 5'b0_0_0_00);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'h1, 5'b0_0_1_00};
    tbl[1]  = '{1'b1, 4'h2, 5'b0_0_1_00};
    tbl[2]  = '{1'b1, 4'h3, 5'b0_0_1_00};
    tbl[3]  = '{1'b1, 4'h4, 5'b1_0_0_00};
    tbl[4]  = '{1'b0, 4'h0, 5'b1_0_0_00};
    tbl[5]  = '{1'b1, 4'h1, 5'b1_0_0_00};
    tbl[6]  = '{1'b0, 4'h0, 5'b1_0_0_00};
    tbl[7]  = '{1'b0, 4'h0, 5'b1_0_0_00};
    tbl[8]  = '{1'b0, 4'h0, 5'b1_0_0_00};
    tbl[9]  = '{1'b0, 4'h0, 5'b1_0_0_00};
    tbl[10] = '{1'b0, 4'h0, 5'b1_0_0_00};
    tbl[11] = '{1'b0, 4'h0, 5'b0_0_0_00};
    tbl[12] = '{1'b1, 4'h1, 5'b0_0_1_00};
    tbl[13] = '{1'b1, 4'h2, 5'b0_0_1_00};
    tbl[14] = '{1'b1, 4'h3, 5'b0_0_1_00};
    tbl[15] = '{1'b1, 4'h5, 5'b0_0_0_01};
    tbl[16] = '{1'b1, 4'h9, 5'b0_0_1_01};
    tbl[17] = '{1'b1, 4'h2, 5'b0_0_1_01};

    dv = 1'b0; dg = '0; ho = 1'b0; cl = 1'b0; nc = '0; reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_out("reset_state", 5'b0_0_0_00);

    // Basic open window and a wrong code, from the vector table.
    for (int i = 0; i < NTBL; i++) begin
      step(tbl[i].dv, tbl[i].d, 1'b0, 1'b0, 16'h0);
      chk_out($sformatf("tbl_row%0d", i), tbl[i].want);
    end

    // Three wrong codes -> lockout of exactly LOCK_C cycles; correct code ignored meanwhile.
    do_reset();
    enter_code(16'h1235); chk_out("fail_1", 5'b0_0_0_01);
    enter_code(16'h1235); chk_out("fail_2", 5'b0_0_0_10);
    enter_code(16'h1235); chk_out("lockout_enter", 5'b0_1_0_00);
    cnt = int'(lock);
    opened = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) step(1'b1, code_digit(DEF_CODE, i), 1'b0, 1'b0, 16'h0);
      else idle();
      cnt += int'(lock);
      if (door || entry) opened++;
    end
    check_int("lockout_len", cnt, LOCK_C);
    check_int("lockout_ignores_digits", opened, 0);
    chk_out("lockout_exit", 5'b0_0_0_00);

    // Entry timeout keeps fail_count; a digit on the timeout cycle still counts.
    do_reset();
    enter_code(16'h1235); chk_out("tmo_pre_fail", 5'b0_0_0_01);
    step(1'b1, 4'h1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 4'h2, 1'b0, 1'b0, 16'h0);
    repeat (TMO - 1) idle();
    chk_out("tmo_still_active", 5'b0_0_1_01);
    idle();
    chk_out("tmo_abandon", 5'b0_0_0_01);
    enter_code(DEF_CODE); chk_out("tmo_then_open", 5'b1_0_0_00);
    cnt = int'(door);
    repeat (10) begin idle(); cnt += int'(door); end
    check_int("open_len", cnt, OPEN_C);
    step(1'b1, 4'h1, 1'b0, 1'b0, 16'h0);
    repeat (TMO - 1) idle();
    for (int i = 1; i < 4; i++) step(1'b1, code_digit(DEF_CODE, i), 1'b0, 1'b0, 16'h0);
    chk_out("tmo_digit_wins", 5'b1_0_0_00);

    // Hold-open overrides lockout and abandons a partial entry.
    do_reset();
    repeat (3) enter_code(16'h1235);
    repeat (3) idle();
    chk_out("hold_pre", 5'b0_1_0_00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0, 1'b1, 1'b0, 16'h0);
      chk_out($sformatf("hold_active%0d", i), 5'b1_0_0_00);
    end
    idle(); chk_out("hold_release", 5'b0_0_0_00);
    step(1'b1, 4'h1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 4'h2, 1'b1, 1'b0, 16'h0);
    chk_out("hold_abandon", 5'b1_0_0_00);
    idle();
    enter_code(DEF_CODE); chk_out("hold_then_open", 5'b1_0_0_00);

    // Code programming (or fixed code) followed by async reset mid-open.
    do_reset();
    enter_code(DEF_CODE); chk_out("prog_open", 5'b1_0_0_00);
    step(1'b0, 4'h0, 1'b0, 1'b1, 16'h9876);
    repeat (10) idle();
    chk_out("prog_closed", 5'b0_0_0_00);
    enter_code(DEF_CODE);
`ifdef CODE_PROGRAM_EN
    chk_out("prog_old_rejected", 5'b0_0_0_01);
    repeat (10) idle();
    enter_code(16'h9876); chk_out("prog_new_opens", 5'b1_0_0_00);
`else
    chk_out("fixed_code_opens", 5'b1_0_0_00);
    repeat (10) idle();
    enter_code(16'h9876); chk_out("fixed_new_rejected", 5'b0_0_0_01);
    enter_code(DEF_CODE); chk_out("fixed_reopen", 5'b1_0_0_00);
`endif
    repeat (4) idle();
    chk_out("pre_async_open", 5'b1_0_0_00);
    async_reset();
    chk_out("async_reset_state", 5'b0_0_0_00);
    enter_code(DEF_CODE); chk_out("code_reverted", 5'b1_0_0_00);

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic        rdv;
      logic        rho;
      logic        rcl;
      logic [3:0]  rd;
      logic [15:0] rnc;
      rho = m_hold ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 199) == 0);
      rdv = ($urandom_range(0, 9) < 4);
      rd  = ($urandom_range(0, 9) < 7) ? code_digit(m_code, m_digits.size())
                                       : 4'($urandom_range(0, 15));
      rcl = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       rnc = 16'h9876;
        1:       rnc = DEF_CODE;
        default: rnc = 16'($urandom);
      endcase
      step(rdv, rd, rho, rcl, rnc);
      chk_out($sformatf("rand_cyc%0d", i), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dorm_keypad_lock.md
Name: dorm_keypad_lock

Overview:
- Parametrised keypad door controller for dorm entrances; successor to the single-bit correct/incorrect door lock.
- Accepts a multi-digit code one digit per strobe and opens the door for a timed window.
- Counts consecutive failures, enforcing a timed lockout after too many.
- Keeps a hold-open override (dining-hall / event mode) and sits between the keypad scanner and the door strike driver.

Parameters:
- CODE_DIGITS, 4, number of digits per code entry (>=1).
- DIGIT_W, 4, bits per digit.
- DEFAULT_CODE, 16'h1234, code after reset; width CODE_DIGITS*DIGIT_W, digit 0 in the most-significant slice.
- OPEN_CYCLES, 500, cycles the door stays open after a correct code (>=1).
- ENTRY_TIMEOUT, 200, maximum idle cycles between digits before the entry is abandoned (>=1).
- MAX_FAIL, 3, consecutive wrong codes that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1000, lockout duration (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- digit_valid  input  1  one-cycle strobe: digit is valid.
- digit  input  DIGIT_W  keypad digit value.
- hold_open  input  1  level override: door held open while high.
- code_load  input  1  strobe: program new code (see Optional Feature).
- new_code  input  CODE_DIGITS*DIGIT_W  code to program.
- door_open  output  1  drives door strike; high = unlocked.
- lockout  output  1  high while in lockout.
- entry_active  output  1  high while a partial code is in progress.
- fail_count  output  $clog2(MAX_FAIL+1)  current consecutive failure count.

Behaviour:
- Reset (async, any state): state=LOCKED, all timers and digit index cleared, code register=DEFAULT_CODE. Outputs: door_open=0, lockout=0, entry_active=0, fail_count=0. All outputs are registered.
- States: LOCKED, ENTRY, OPEN, LOCKOUT, HOLD.
- LOCKED:
  - digit_valid: compare the digit with slice 0; set match flag = equal; index=1; go to ENTRY. When CODE_DIGITS==1, evaluate immediately as in ENTRY completion.
- ENTRY:
  - Each digit_valid ANDs the match flag with (digit==slice[index]), increments index, and reloads the idle timer.
  - Completion on the CODE_DIGITS-th digit:
    - Match: go to OPEN, load OPEN_CYCLES, clear fail_count. door_open rises the cycle after the final strobe.
    - Mismatch: increment fail_count. If it reaches MAX_FAIL, go to LOCKOUT, load LOCKOUT_CYCLES, clear fail_count. Otherwise go to LOCKED.
  - Idle timer reaching ENTRY_TIMEOUT with no digit: return to LOCKED; fail_count unchanged.
  - entry_active=1 only in ENTRY.
- OPEN:
  - door_open=1; the timer counts down each cycle.
  - Expiry: LOCKED, door_open falls; total open time is exactly OPEN_CYCLES cycles.
  - digit_valid is ignored.
- LOCKOUT:
  - lockout=1, door_open=0; digits ignored.
  - Expiry after exactly LOCKOUT_CYCLES cycles: LOCKED.
- HOLD:
  - hold_open=1 in any state takes priority. Next cycle: HOLD, door_open=1, entry abandoned, timers cleared.
  - Overrides LOCKOUT (emergency egress); fail_count is cleared on entry to HOLD.
  - hold_open falling: LOCKED, door_open=0 the following cycle.
- Simultaneous events:
  - Priority is reset > hold_open > digit_valid > timer expiry.
  - digit_valid in the same cycle as an ENTRY timeout counts as a digit.
  - code_load together with the OPEN expiry cycle is still accepted.
- Timers are sized to $clog2 of their maximum; no wrap-around is possible because they are reloaded only on state entry.

Optional Feature:
- Macro CODE_PROGRAM_EN.
- Defined: code_load pulsed while in OPEN or HOLD copies new_code into the code register on that edge; the new code applies to the next entry. code_load in other states is ignored.
- Not defined: code_load and new_code are ignored and the code is fixed at DEFAULT_CODE. The ports remain present so the interface is identical.

Test Plan:
- Default params, OPEN_CYCLES=8: strobe digits 1,2,3,4 -> door_open=1 the cycle after digit 4 for exactly 8 cycles; fail_count=0.
- MAX_FAIL=3, LOCKOUT_CYCLES=16: enter 1,2,3,5 three times -> fail_count goes 1,2, then lockout=1 for 16 cycles with fail_count=0; a correct code during lockout does not open.
- ENTRY_TIMEOUT=10: enter 1,2 then idle 10 cycles -> entry_active drops, state LOCKED, fail_count unchanged; a subsequent 1,2,3,4 opens.
- Mid-lockout, assert hold_open for 5 cycles -> door_open=1 the next cycle, lockout=0; on release door_open=0 one cycle later.
- CODE_PROGRAM_EN defined: open with 1234, pulse code_load with 16'h9876 -> after relock, 1234 fails and 9876 opens. Without the macro, 1234 still opens.
- Assert reset asynchronously during OPEN with 3 cycles remaining -> door_open=0 immediately, all outputs at reset values, code reverts to DEFAULT_CODE.
